// File: rtl/pmod_pir_pkg.sv
// -----------------------------------------------------------------------------
// pmod_pir_pkg
// Shared types and constants for the Pmod PIR conditioning path.
//   pir_state_e     : motion qualification FSM states
//   EVENT_CNT_W     : width of the software-visible motion event counter
//   EVENT_CNT_MAX   : saturation value of the event counter
//   event_cnt_next(): next value of the saturating, clearable event counter
// -----------------------------------------------------------------------------
package pmod_pir_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL_HI = 3'd1,
    ACTIVE  = 3'd2,
    QUAL_LO = 3'd3,
    HOLDOFF = 3'd4
  } pir_state_e;

  localparam int                     EVENT_CNT_W   = 16;
  localparam logic [EVENT_CNT_W-1:0] EVENT_CNT_MAX = 16'hFFFF;
  localparam logic [EVENT_CNT_W-1:0] EVENT_CNT_ONE = 16'h0001;
  localparam logic [EVENT_CNT_W-1:0] EVENT_CNT_NIL = 16'h0000;

  // A clear in the same cycle as an event still records that event, so
  // software never loses the onset that raced with its clear.
  function automatic logic [EVENT_CNT_W-1:0] event_cnt_next(
    input logic [EVENT_CNT_W-1:0] cnt,
    input logic                   evt,
    input logic                   clr
  );
    logic [EVENT_CNT_W-1:0] nxt;
    if (clr) begin
      nxt = evt ? EVENT_CNT_ONE : EVENT_CNT_NIL;
    end else if (evt && (cnt != EVENT_CNT_MAX)) begin
      nxt = cnt + EVENT_CNT_ONE;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pmod_sync2.sv
// -----------------------------------------------------------------------------
// pmod_sync2
// Generic WIDTH-bit two-flop synchroniser for asynchronous Pmod pins.
//   clk    : destination clock
//   resetn : asynchronous active-low reset, clears both stages
//   d      : asynchronous input bits
//   q      : synchronised bits (second flop stage)
// -----------------------------------------------------------------------------
module pmod_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture; meta_r may go metastable and is only read by sync_r.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pmod_pir_detect.sv
// -----------------------------------------------------------------------------
// pmod_pir_detect
// Conditions the raw Pmod pins ahead of the PIR remap stage / AXI GPIO:
// synchronises every pin, debounces the PIR output, and produces a motion
// level, a one-cycle onset event, a sticky interrupt and a saturating count.
//   clk          : system (AXI) clock
//   resetn       : asynchronous active-low reset
//   pin_i        : raw Pmod pins (top row 3:0, bottom row 7:4)
//   sync_o       : synchronised pins for the remap stage
//   motion       : debounced PIR level
//   motion_event : one-cycle pulse per qualified onset
//   irq_en       : interrupt enable
//   irq_clr      : interrupt clear (level)
//   irq          : sticky interrupt
//   count_clr    : event counter clear
//   event_count  : saturating number of motion events
// -----------------------------------------------------------------------------
module pmod_pir_detect
  import pmod_pir_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int PIR_BIT         = 0,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int HOLDOFF_CYCLES  = 50000000,
  parameter int CNT_W           = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       pin_i,
  output logic [WIDTH-1:0]       sync_o,
  output logic                   motion,
  output logic                   motion_event,
  input  logic                   irq_en,
  input  logic                   irq_clr,
  output logic                   irq,
  input  logic                   count_clr,
  output logic [EVENT_CNT_W-1:0] event_count
);

  localparam int NEED_CNT = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES
                                                               : HOLDOFF_CYCLES;

  // Reject parameter sets the counter logic cannot honour.
  generate
    if ((PIR_BIT < 0) || (PIR_BIT >= WIDTH)) begin : g_bad_pir_bit
      $error("pmod_pir_detect: PIR_BIT out of range 0..WIDTH-1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("pmod_pir_detect: DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLDOFF_CYCLES < 0) begin : g_bad_holdoff
      $error("pmod_pir_detect: HOLDOFF_CYCLES must be >= 0");
    end
    if ((CNT_W < 1) || ((NEED_CNT >> CNT_W) != 0)) begin : g_bad_cnt_w
      $error("pmod_pir_detect: CNT_W too narrow for DEBOUNCE/HOLDOFF cycles");
    end
  endgenerate

  // Counters compare against the last count value instead of adding one,
  // which is equivalent to cnt+1==N but needs no extra carry bit.
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1)
                                                                : CNT_ZERO;
  localparam pir_state_e       EXIT_STATE = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;

  logic [WIDTH-1:0] sync_s;
  logic             pir_s;
  pir_state_e       state_r;
  pir_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             motion_nxt_s;
  logic             event_nxt_s;
  logic             motion_r;
  logic             event_r;
  logic             irq_r;
  logic [EVENT_CNT_W-1:0] count_r;

  pmod_sync2 #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pin_i),
    .q      (sync_s)
  );

  assign pir_s = sync_s[PIR_BIT];

  // FSM state and shared debounce/holdoff counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; the counter restarts on every state change.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (pir_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt_s = ACTIVE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = QUAL_HI;
            cnt_nxt_s   = CNT_ONE;
          end
        end else begin
          cnt_nxt_s = CNT_ZERO;
        end
      end
      QUAL_HI: begin
        if (!pir_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_nxt_s = ACTIVE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ACTIVE: begin
        if (!pir_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt_s = EXIT_STATE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = QUAL_LO;
            cnt_nxt_s   = CNT_ONE;
          end
        end else begin
          cnt_nxt_s = CNT_ZERO;
        end
      end
      QUAL_LO: begin
        if (pir_s) begin
          // Dropout shorter than the debounce window: motion never fell.
          state_nxt_s = ACTIVE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_nxt_s = EXIT_STATE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      HOLDOFF: begin
        // The sensor is ignored here; IDLE re-qualifies from scratch.
        if (cnt_r == HOLD_LAST) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    motion_nxt_s = (state_nxt_s == ACTIVE) || (state_nxt_s == QUAL_LO);
    event_nxt_s  = (state_nxt_s == ACTIVE) && ((state_r == IDLE) || (state_r == QUAL_HI));
  end

  // Registered motion level and onset pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      motion_r <= 1'b0;
      event_r  <= 1'b0;
    end else begin
      motion_r <= motion_nxt_s;
      event_r  <= event_nxt_s;
    end
  end

  // Sticky interrupt; a new event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_r <= 1'b0;
    end else if (event_r && irq_en) begin
      irq_r <= 1'b1;
    end else if (irq_clr) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end

  // Saturating event counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= EVENT_CNT_NIL;
    end else begin
      count_r <= event_cnt_next(count_r, event_r, count_clr);
    end
  end

  assign sync_o       = sync_s;
  assign motion       = motion_r;
  assign motion_event = event_r;
  assign irq          = irq_r;
  assign event_count  = count_r;

endmodule

// File: tb/tb_pmod_pir_detect.sv
// -----------------------------------------------------------------------------
// tb_pmod_pir_detect
// Directed bench for pmod_pir_detect (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8).
// Stimulus pushes hand-computed expectations tagged with the cycle they are
// due; a monitor on the falling edge pops and compares them, and separately
// matches every motion_event pulse against a queue of expected event cycles.
// -----------------------------------------------------------------------------
module tb_pmod_pir_detect;

  localparam int SEL_SYNC = 0;
  localparam int SEL_MOT  = 1;
  localparam int SEL_EVT  = 2;
  localparam int SEL_IRQ  = 3;
  localparam int SEL_CNT  = 4;

  typedef struct {
    int          at;
    int          sel;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  pin_i;
  logic [7:0]  sync_o;
  logic        motion;
  logic        motion_event;
  logic        irq_en;
  logic        irq_clr;
  logic        irq;
  logic        count_clr;
  logic [15:0] event_count;

  exp_t exp_q[$];
  int   evt_q[$];
  int   cyc    = 0;
  int   t0     = 0;
  int   checks = 0;
  int   errors = 0;

  pmod_pir_detect #(
    .WIDTH           (8),
    .PIR_BIT         (0),
    .DEBOUNCE_CYCLES (4),
    .HOLDOFF_CYCLES  (8),
    .CNT_W           (8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pin_i        (pin_i),
    .sync_o       (sync_o),
    .motion       (motion),
    .motion_event (motion_event),
    .irq_en       (irq_en),
    .irq_clr      (irq_clr),
    .irq          (irq),
    .count_clr    (count_clr),
    .event_count  (event_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      SEL_SYNC: return {8'h00, sync_o};
      SEL_MOT:  return {15'd0, motion};
      SEL_EVT:  return {15'd0, motion_event};
      SEL_IRQ:  return {15'd0, irq};
      default:  return event_count;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_SYNC: return "sync_o";
      SEL_MOT:  return "motion";
      SEL_EVT:  return "motion_event";
      SEL_IRQ:  return "irq";
      default:  return "event_count";
    endcase
  endfunction

  // Monitor: compare due expectations and match event pulses.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at == cyc) begin
        checks++;
        if (actual(exp_q[i].sel) !== exp_q[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%h required=%h",
                   sel_name(exp_q[i].sel), cyc, actual(exp_q[i].sel), exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
    if (motion_event === 1'b1) begin
      checks++;
      if ((evt_q.size() > 0) && (evt_q[0] == cyc)) begin
        void'(evt_q.pop_front());
      end else begin
        errors++;
        $display("FAIL event_unexpected cyc=%0d actual=1 required=0", cyc);
      end
    end else if ((evt_q.size() > 0) && (evt_q[0] <= cyc)) begin
      checks++;
      errors++;
      $display("FAIL event_missing cyc=%0d actual=0 required=1 (due cyc %0d)", cyc, evt_q[0]);
      void'(evt_q.pop_front());
    end
  end

  task automatic mark();
    t0 = cyc;
  endtask

  task automatic at(input int rel);
    while (cyc < t0 + rel) @(negedge clk);
  endtask

  task automatic expect_at(input int rel, input int sel, input logic [15:0] val);
    exp_t e;
    e.at  = t0 + rel;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // From IDLE with the PIR low: one full onset, then back to IDLE.
  task automatic pulse(input logic clr, input logic [15:0] cnt, input logic irq_exp);
    mark();
    pin_i = 8'hA5;
    evt_q.push_back(t0 + 6);
    expect_at(5, SEL_MOT, 16'd0);
    expect_at(6, SEL_MOT, 16'd1);
    expect_at(6, SEL_EVT, 16'd1);
    expect_at(7, SEL_EVT, 16'd0);
    expect_at(7, SEL_CNT, cnt);
    expect_at(7, SEL_IRQ, {15'd0, irq_exp});
    at(6);
    count_clr = clr;
    pin_i     = 8'hA4;
    at(7);
    count_clr = 1'b0;
    at(21);
  endtask

  initial begin
    resetn    = 1'b0;
    pin_i     = 8'hA5;
    irq_en    = 1'b1;
    irq_clr   = 1'b0;
    count_clr = 1'b0;

    // Held in reset: everything stays 0.
    @(negedge clk);
    mark();
    for (int d = 1; d <= 3; d++) begin
      expect_at(d, SEL_SYNC, 16'h0000);
      expect_at(d, SEL_MOT,  16'd0);
      expect_at(d, SEL_IRQ,  16'd0);
      expect_at(d, SEL_CNT,  16'd0);
    end
    at(3);

    // Release with PIR (bit 0 of A5) already high.
    resetn = 1'b1;
    mark();
    expect_at(1, SEL_SYNC, 16'h0000);
    expect_at(2, SEL_SYNC, 16'h00A5);
    expect_at(5, SEL_MOT,  16'd0);
    expect_at(6, SEL_MOT,  16'd1);
    expect_at(6, SEL_EVT,  16'd1);
    expect_at(7, SEL_EVT,  16'd0);
    expect_at(6, SEL_IRQ,  16'd0);
    expect_at(7, SEL_IRQ,  16'd1);
    expect_at(6, SEL_CNT,  16'd0);
    expect_at(7, SEL_CNT,  16'd1);
    evt_q.push_back(t0 + 6);
    at(8);

    // Short dropout (2 cycles) in ACTIVE: motion holds, no event.
    mark();
    pin_i = 8'hA4;
    for (int d = 1; d <= 8; d++) expect_at(d, SEL_MOT, 16'd1);
    expect_at(8, SEL_CNT, 16'd1);
    at(2);
    pin_i = 8'hA5;
    at(8);

    // Long dropout, holdoff ignores re-assertion, irq set/clear priority.
    mark();
    pin_i = 8'hA4;
    expect_at(5,  SEL_MOT, 16'd1);
    expect_at(6,  SEL_MOT, 16'd0);
    expect_at(10, SEL_MOT, 16'd0);
    expect_at(17, SEL_MOT, 16'd0);
    expect_at(18, SEL_MOT, 16'd1);
    expect_at(10, SEL_IRQ, 16'd0);
    expect_at(18, SEL_IRQ, 16'd0);
    expect_at(19, SEL_IRQ, 16'd1);
    expect_at(20, SEL_IRQ, 16'd1);
    expect_at(21, SEL_IRQ, 16'd0);
    expect_at(18, SEL_CNT, 16'd1);
    expect_at(19, SEL_CNT, 16'd2);
    evt_q.push_back(t0 + 18);
    at(8);
    pin_i = 8'hA5;
    at(9);
    irq_clr = 1'b1;
    at(10);
    irq_clr = 1'b0;
    at(18);
    irq_clr = 1'b1;
    at(19);
    irq_clr = 1'b0;
    irq_en  = 1'b0;
    at(20);
    irq_clr = 1'b1;
    at(21);
    irq_clr = 1'b0;

    // Back to IDLE, then a 3-cycle glitch that must not qualify.
    mark();
    pin_i = 8'hA4;
    expect_at(5,  SEL_MOT, 16'd1);
    expect_at(6,  SEL_MOT, 16'd0);
    expect_at(20, SEL_MOT, 16'd0);
    expect_at(22, SEL_MOT, 16'd0);
    expect_at(22, SEL_CNT, 16'd2);
    at(15);
    pin_i = 8'hA5;
    at(18);
    pin_i = 8'hA4;
    at(24);

    // Saturation from near-max, then clear interactions.
    mark();
    force dut.count_r = 16'hFFFE;
    #1;
    release dut.count_r;
    expect_at(1, SEL_CNT, 16'hFFFE);
    at(1);
    pulse(1'b0, 16'hFFFF, 1'b0);
    pulse(1'b0, 16'hFFFF, 1'b0);
    pulse(1'b1, 16'd1, 1'b0);
    pulse(1'b0, 16'd2, 1'b0);
    mark();
    count_clr = 1'b1;
    expect_at(1, SEL_CNT, 16'd0);
    at(1);
    count_clr = 1'b0;
    irq_en    = 1'b1;
    pulse(1'b0, 16'd1, 1'b1);

    // Short async reset while in QUAL_HI: outputs clear, no event afterwards.
    mark();
    pin_i = 8'hA5;
    expect_at(5,  SEL_SYNC, 16'h0000);
    expect_at(5,  SEL_MOT,  16'd0);
    expect_at(5,  SEL_IRQ,  16'd0);
    expect_at(5,  SEL_CNT,  16'd0);
    expect_at(6,  SEL_SYNC, 16'h00A4);
    expect_at(25, SEL_MOT,  16'd0);
    expect_at(25, SEL_CNT,  16'd0);
    at(4);
    pin_i = 8'hA4;
    #1;
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    at(26);

    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL pending_%s due=%0d actual=unchecked required=%h",
               sel_name(exp_q[i].sel), exp_q[i].at, exp_q[i].val);
    end
    foreach (evt_q[i]) begin
      checks++;
      errors++;
      $display("FAIL event_pending due=%0d actual=none required=1", evt_q[i]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time=%0t actual=running required=finished", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
